// File: rtl/dice_roller_if.sv
// Button and display-decoder bundle of the dice front end.
// Signal prefixes are from the front end's point of view (i_ in, o_ out).
// The environment (button side, decoder side) uses the master modport.
interface dice_roller_if;
  logic       i_btn;
  logic [2:0] o_num;
  logic       o_rolling;
  logic       o_done;

  modport master (output i_btn, input o_num, o_rolling, o_done);
  modport slave  (input i_btn, output o_num, o_rolling, o_done);
endinterface

// File: rtl/dice_roller.sv
// Dice front end: debounced button spins faces 1..6, decelerates after release, holds final face.
// Latency: press/release act DB_CYCLES+3 edges after the button is stable; all outputs registered.
// Backpressure: none; free-running. Optional DICE_LFSR_EN swaps sequential advance for LFSR faces.
module dice_roller #(
  parameter int unsigned DB_CYCLES   = 16,
  parameter int unsigned TICK_BASE   = 4,
  parameter int unsigned TICK_STEP   = 2,
  parameter int unsigned DECEL_STEPS = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  dice_roller_if.slave bus
);

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int KW  = $clog2(DECEL_STEPS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROLL  = 2'd1,
    ST_DECEL = 2'd2,
    ST_SHOW  = 2'd3
  } state_t;

  // Sequential face order 1..6 wrapping; blank (0) starts at face 1.
  function automatic logic [2:0] seq_next(input logic [2:0] cur);
    return ((cur == 3'd0) || (cur >= 3'd6)) ? 3'd1 : cur + 3'd1;
  endfunction

  logic [1:0]     r_sync;
  logic           r_db_lvl;
  logic           r_db_prev;
  logic [DBW-1:0] r_db_cnt;
  logic           w_press;
  logic           w_release;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [2:0]     r_num;
  logic [2:0]     w_num_nxt;
  logic [15:0]    r_tick;
  logic [15:0]    w_tick_nxt;
  logic [KW-1:0]  r_k;
  logic [KW-1:0]  w_k_nxt;
  logic           r_rolling;
  logic           w_rolling_nxt;
  logic           r_done;
  logic           w_done_nxt;
  logic [2:0]     w_adv_num;
  logic [31:0]    w_decel_lim;

  // Two-flop synchronizer, then a level debouncer that only flips after a full run of disagreeing samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync    <= 2'b00;
      r_db_lvl  <= 1'b0;
      r_db_prev <= 1'b0;
      r_db_cnt  <= '0;
    end else begin
      r_sync    <= {r_sync[0], bus.i_btn};
      r_db_prev <= r_db_lvl;
      if (r_sync[1] != r_db_lvl) begin
        if (r_db_cnt == DBW'(DB_CYCLES - 1)) begin
          r_db_lvl <= r_sync[1];
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DBW'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_press   = r_db_lvl & ~r_db_prev;
  assign w_release = ~r_db_lvl & r_db_prev;

`ifdef DICE_LFSR_EN
  logic [7:0] r_lfsr;
  logic [2:0] w_rand_face;

  // Free-running Fibonacci LFSR (taps 8,6,5,4), stepping every cycle regardless of state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= 8'h01;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  // Fold the 3 low LFSR bits onto 1..6 and force a visible change when it repeats the current face.
  always_comb begin
    w_rand_face = r_lfsr[2:0];
    if (r_lfsr[2:0] == 3'd0) w_rand_face = 3'd6;
    if (r_lfsr[2:0] == 3'd7) w_rand_face = 3'd1;
    w_adv_num = (w_rand_face == r_num) ? seq_next(r_num) : w_rand_face;
  end
`else
  assign w_adv_num = seq_next(r_num);
`endif

  // Advance period while decelerating stretches by TICK_STEP per completed step.
  assign w_decel_lim = TICK_BASE + (32'(r_k) * TICK_STEP) - 32'd1;

  // State register and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_num     <= 3'd0;
      r_tick    <= 16'd0;
      r_k       <= '0;
      r_rolling <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_num     <= w_num_nxt;
      r_tick    <= w_tick_nxt;
      r_k       <= w_k_nxt;
      r_rolling <= w_rolling_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state logic: button events take priority over a face advance on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_num_nxt   = r_num;
    w_tick_nxt  = r_tick;
    w_k_nxt     = r_k;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE, ST_SHOW: begin
        if (w_press) begin
          w_state_nxt = ST_ROLL;
          w_num_nxt   = w_adv_num;
          w_tick_nxt  = 16'd0;
        end
      end
      ST_ROLL: begin
        if (w_release) begin
          w_state_nxt = ST_DECEL;
          w_tick_nxt  = 16'd0;
          w_k_nxt     = KW'(1);
        end else if (r_tick == 16'(TICK_BASE - 1)) begin
          w_num_nxt  = w_adv_num;
          w_tick_nxt = 16'd0;
        end else begin
          w_tick_nxt = r_tick + 16'd1;
        end
      end
      ST_DECEL: begin
        if (w_press) begin
          w_state_nxt = ST_ROLL;
          w_tick_nxt  = 16'd0;
          w_k_nxt     = '0;
        end else if (32'(r_tick) == w_decel_lim) begin
          w_num_nxt  = w_adv_num;
          w_tick_nxt = 16'd0;
          if (r_k == KW'(DECEL_STEPS)) begin
            w_state_nxt = ST_SHOW;
            w_done_nxt  = 1'b1;
          end else begin
            w_k_nxt = r_k + KW'(1);
          end
        end else begin
          w_tick_nxt = r_tick + 16'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_num_nxt   = 3'd0;
        w_tick_nxt  = 16'd0;
        w_k_nxt     = '0;
      end
    endcase
    w_rolling_nxt = (w_state_nxt == ST_ROLL) || (w_state_nxt == ST_DECEL);
  end

  assign bus.o_num     = r_num;
  assign bus.o_rolling = r_rolling;
  assign bus.o_done    = r_done;

endmodule

// File: tb/tb_dice_roller.sv
// Directed plus randomized bench for dice_roller with a cycle-level reference model.
module tb_dice_roller;
  localparam int DB = 16;
  localparam int TB = 4;
  localparam int TS = 2;
  localparam int DS = 6;

  localparam int M_IDLE  = 0;
  localparam int M_ROLL  = 1;
  localparam int M_DECEL = 2;
  localparam int M_SHOW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dice_roller_if dif ();

  dice_roller #(
    .DB_CYCLES  (DB),
    .TICK_BASE  (TB),
    .TICK_STEP  (TS),
    .DECEL_STEPS(DS)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (dif.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: the button is seen two edges late; the debounced level flips after DB
  // consecutive disagreeing samples; the resulting event is acted on one edge later.
  bit m_s1, m_s2, m_lvl, m_rise, m_fall, m_done, m_roll;
  int m_run, m_mode, m_num, m_since, m_k;

  int exp_d[6] = '{6, 8, 10, 12, 14, 16};
  int exp_r[4] = '{6, 14, 20, 24};
  int deltas[$];
  int offs[$];

  task automatic chk(input string tag, input logic [15:0] obs, input int exp);
    checks++;
    assert (obs === 16'(exp)) else begin
      failures++;
      $display("FAIL %s: observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
      $error("check %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic btn, input logic rst_i);
    bit press, rel_ev, samp;
    if (rst_i) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rise = 0; m_fall = 0;
      m_run = 0; m_mode = M_IDLE; m_num = 0; m_since = 0; m_k = 0;
      m_done = 0; m_roll = 0;
    end else begin
      press  = m_rise;
      rel_ev = m_fall;
      samp = m_s2;
      m_s2 = m_s1;
      m_s1 = btn;
      m_rise = 0;
      m_fall = 0;
      if (samp != m_lvl) begin
        m_run++;
        if (m_run == DB) begin
          m_lvl = samp;
          m_run = 0;
          if (samp) m_rise = 1; else m_fall = 1;
        end
      end else begin
        m_run = 0;
      end
      m_done = 0;
      case (m_mode)
        M_IDLE, M_SHOW: if (press) begin
          m_mode = M_ROLL; m_num = (m_num % 6) + 1; m_since = 0;
        end
        M_ROLL: if (rel_ev) begin
          m_mode = M_DECEL; m_k = 1; m_since = 0;
        end else begin
          m_since++;
          if (m_since == TB) begin m_num = (m_num % 6) + 1; m_since = 0; end
        end
        default: if (press) begin
          m_mode = M_ROLL; m_since = 0; m_k = 0;
        end else begin
          m_since++;
          if (m_since == TB + m_k * TS) begin
            m_num = (m_num % 6) + 1;
            m_since = 0;
            if (m_k == DS) begin m_mode = M_SHOW; m_done = 1; end
            else m_k++;
          end
        end
      endcase
      m_roll = (m_mode == M_ROLL) || (m_mode == M_DECEL);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    model_edge(dif.i_btn, rst);
    chk("num", 16'(dif.o_num), m_num);
    chk("rolling", 16'(dif.o_rolling), int'(m_roll));
    chk("done", 16'(dif.o_done), int'(m_done));
    chk("num_range", 16'(dif.o_num <= 3'd6), 1);
  endtask

  initial begin
    int last, rel, ndone, nchg, nlow, n;
    bit seen;
    logic [2:0] prev;

    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rise = 0; m_fall = 0; m_done = 0; m_roll = 0;
    m_run = 0; m_mode = M_IDLE; m_num = 0; m_since = 0; m_k = 0;
    dif.i_btn = 1'b0;
    rst = 1'b1;

    // Reset held three cycles while the button toggles.
    for (int i = 0; i < 3; i++) begin
      dif.i_btn = ~dif.i_btn;
      step();
      chk("rst_num", 16'(dif.o_num), 0);
      chk("rst_rolling", 16'(dif.o_rolling), 0);
      chk("rst_done", 16'(dif.o_done), 0);
    end
    rst = 1'b0;
    dif.i_btn = 1'b0;
    step();
    chk("post_rst_num", 16'(dif.o_num), 0);
    chk("post_rst_rolling", 16'(dif.o_rolling), 0);

    // Short pulses must never be accepted as a press.
    for (int r = 0; r < 5; r++) begin
      dif.i_btn = 1'b1; repeat (10) step();
      dif.i_btn = 1'b0; repeat (10) step();
    end
    chk("bounce_num", 16'(dif.o_num), 0);
    chk("bounce_rolling", 16'(dif.o_rolling), 0);

    // Held press: ROLL on edge 19, then a new face every 4 cycles.
    dif.i_btn = 1'b1;
    repeat (18) step();
    chk("edge18_rolling", 16'(dif.o_rolling), 0);
    step();
    chk("edge19_rolling", 16'(dif.o_rolling), 1);
    chk("edge19_num", 16'(dif.o_num), 1);
    for (int i = 0; i < 7; i++) begin
      repeat (4) step();
      chk("roll_seq", 16'(dif.o_num), ((i + 1) % 6) + 1);
    end

    // Release timed so the release edge lands with NUM=3.
    n = 0;
    while (dif.o_num != 3'd5 && n < 40) begin step(); n++; end
    chk("wait_num5", 16'(dif.o_num), 5);
    dif.i_btn = 1'b0;
    repeat (19) step();
    chk("release_num", 16'(dif.o_num), 3);
    last = cyc; prev = dif.o_num; seen = 0; deltas.delete();
    for (int i = 0; i < 150 && !seen; i++) begin
      step();
      if (dif.o_num != prev) begin deltas.push_back(cyc - last); last = cyc; prev = dif.o_num; end
      if (dif.o_done) seen = 1;
    end
    chk("decel_done_seen", 16'(seen), 1);
    chk("decel_adv_count", 16'(deltas.size()), 6);
    for (int i = 0; i < 6; i++)
      chk("decel_interval", 16'((i < deltas.size()) ? deltas[i] : 0), exp_d[i]);
    chk("final_num", 16'(dif.o_num), 3);
    ndone = 0; nchg = 0; nlow = 0;
    repeat (200) begin
      step();
      if (dif.o_done) ndone++;
      if (dif.o_num != 3'd3) nchg++;
      if (dif.o_rolling) nlow++;
    end
    chk("show_extra_done", 16'(ndone), 0);
    chk("show_num_changes", 16'(nchg), 0);
    chk("show_rolling", 16'(nlow), 0);

    // Re-press during DECEL right after its second advance.
    dif.i_btn = 1'b1;
    repeat (19) step();
    chk("repress_start_num", 16'(dif.o_num), 4);
    repeat (10) step();
    dif.i_btn = 1'b0;
    repeat (16) step();
    dif.i_btn = 1'b1;
    rel = cyc + 3;
    prev = dif.o_num; ndone = 0; nlow = 0; offs.delete();
    for (int i = 0; i < 42; i++) begin
      step();
      if (cyc > rel && dif.o_num != prev) offs.push_back(cyc - rel);
      prev = dif.o_num;
      if (!dif.o_rolling) nlow++;
      if (dif.o_done) ndone++;
    end
    for (int i = 0; i < 4; i++)
      chk("repress_offset", 16'((i < offs.size()) ? offs[i] : 0), exp_r[i]);
    chk("repress_rolling_low", 16'(nlow), 0);
    chk("repress_done", 16'(ndone), 0);

    // Later release restarts deceleration at the first (6-cycle) interval.
    dif.i_btn = 1'b0;
    repeat (19) step();
    last = cyc; prev = dif.o_num; n = 0;
    while (dif.o_num == prev && n < 30) begin step(); n++; end
    chk("redecel_first", 16'(cyc - last), 6);
    n = 0; seen = 0;
    while (!seen && n < 200) begin step(); n++; if (dif.o_done) seen = 1; end
    chk("redecel_done", 16'(seen), 1);

    // Reset in the middle of a roll.
    dif.i_btn = 1'b1;
    n = 0;
    while (!(dif.o_rolling && dif.o_num == 3'd5) && n < 100) begin step(); n++; end
    chk("wait_roll5", 16'(dif.o_num), 5);
    rst = 1'b1;
    step();
    chk("midrst_num", 16'(dif.o_num), 0);
    chk("midrst_rolling", 16'(dif.o_rolling), 0);
    rst = 1'b0;
    n = 0;
    while (!dif.o_rolling && n < 40) begin step(); n++; end
    chk("rearm_latency", 16'(n), 19);
    chk("rearm_num", 16'(dif.o_num), 1);

    // Random button runs with occasional resets, checked cycle by cycle.
    for (int s = 0; s < 60; s++) begin
      dif.i_btn = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 19) == 0);
      step();
      rst = 1'b0;
      repeat ($urandom_range(1, 60)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
